// File: rtl/png_chunk_chk.sv
// PNG chunk checker: serializes a word-packed chunk to bytes, recomputes CRC-32
// over type+data, checks framing and forwards payload bytes downstream.
module png_chunk_chk (
  input  logic        clk,
  input  logic        rst,
  input  logic        val_i,
  output logic        rdy_o,
  input  logic [31:0] dat_i,
  input  logic        lst_i,
  output logic        byt_val_o,
  output logic [7:0]  byt_o,
  output logic [31:0] len_o,
  output logic [31:0] typ_o,
  output logic        done_o,
  output logic        ok_o,
  output logic        err_o
);

  typedef enum logic [2:0] {S_LEN, S_TYP, S_DAT, S_CRC, S_DRN, S_DONE} state_t;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

  state_t      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_lst_q, hold_lst_d;
  logic        hold_vld_q, hold_vld_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] len_sh_q, len_sh_d;
  logic [23:0] typ_sh_q, typ_sh_d;
  logic [23:0] rcv_q, rcv_d;
  logic [31:0] crc_q, crc_d;
  logic        err_q, err_d;
  logic [31:0] len_o_q, len_o_d;
  logic [31:0] typ_o_q, typ_o_d;
  logic        byt_val_q, byt_val_d;
  logic [7:0]  byt_q, byt_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic        err_o_q, err_o_d;

  logic [7:0]  cur_byte;
  logic [31:0] crc_rev;
  logic [31:0] crc_fin;
  logic        consume;
  logic        word_end;
  logic        dat_last;
  logic        accept;
  logic        crc_end;
  logic        word_free;

  // Data bits enter LSB-first into an MSB-first shift register; the final
  // bit reversal turns the result into the usual reflected CRC-32 value.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < 32; gi++) begin : g_rev
    assign crc_rev[gi] = crc_q[31-gi];
  end
  assign crc_fin = ~crc_rev;

  always_comb begin
    case (bidx_q)
      2'd0:    cur_byte = hold_q[31:24];
      2'd1:    cur_byte = hold_q[23:16];
      2'd2:    cur_byte = hold_q[15:8];
      default: cur_byte = hold_q[7:0];
    endcase
  end

  assign consume  = hold_vld_q && (state_q inside {S_LEN, S_TYP, S_DAT, S_CRC});
  assign word_end = (bidx_q == 2'd3);
  assign dat_last = (cnt_q == len_sh_q - 32'd1);

  // Ready when the hold register is empty or frees up at the coming edge.
  assign rdy_o  = !hold_vld_q || (state_q == S_DRN) ||
                  (consume && (word_end || (state_q == S_CRC && cnt_q[1:0] == 2'd3)));
  assign accept = val_i && rdy_o;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_lst_d = hold_lst_q;
    hold_vld_d = hold_vld_q;
    bidx_d     = bidx_q;
    cnt_d      = cnt_q;
    len_sh_d   = len_sh_q;
    typ_sh_d   = typ_sh_q;
    rcv_d      = rcv_q;
    crc_d      = crc_q;
    err_d      = err_q;
    len_o_d    = len_o_q;
    typ_o_d    = typ_o_q;
    byt_val_d  = 1'b0;
    byt_d      = byt_q;
    done_d     = 1'b0;
    ok_d       = ok_q;
    err_o_d    = err_o_q;
    crc_end    = 1'b0;
    word_free  = 1'b0;

    case (state_q)
      S_LEN: if (hold_vld_q) begin
        crc_d    = 32'hFFFF_FFFF;
        len_sh_d = {len_sh_q[23:0], cur_byte};
        cnt_d    = cnt_q + 32'd1;
        if (cnt_q[1:0] == 2'd0) err_d = 1'b0;
        if (cnt_q[1:0] == 2'd3) begin
          len_o_d = len_sh_d;
          cnt_d   = 32'd0;
          if (len_sh_d[31]) begin
            err_d   = 1'b1;
            state_d = S_DRN;
          end else begin
            state_d = S_TYP;
          end
        end
      end
      S_TYP: if (hold_vld_q) begin
        crc_d    = crc_byte(crc_q, cur_byte);
        typ_sh_d = {typ_sh_q[15:0], cur_byte};
        cnt_d    = cnt_q + 32'd1;
        if (cnt_q[1:0] == 2'd3) begin
          typ_o_d = {typ_sh_q, cur_byte};
          cnt_d   = 32'd0;
          state_d = (len_sh_q == 32'd0) ? S_CRC : S_DAT;
        end
      end
      S_DAT: if (hold_vld_q) begin
        crc_d     = crc_byte(crc_q, cur_byte);
        byt_val_d = 1'b1;
        byt_d     = cur_byte;
        cnt_d     = cnt_q + 32'd1;
        if (dat_last) begin
          cnt_d   = 32'd0;
          state_d = S_CRC;
        end
      end
      S_CRC: if (hold_vld_q) begin
        rcv_d = {rcv_q[15:0], cur_byte};
        cnt_d = cnt_q + 32'd1;
        if (cnt_q[1:0] == 2'd3) begin
          crc_end = 1'b1;
          cnt_d   = 32'd0;
          if (hold_lst_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            ok_d    = !err_q && (crc_fin == {rcv_q, cur_byte});
            err_o_d = err_q;
          end else begin
            err_d   = 1'b1;
            state_d = S_DRN;
          end
        end
      end
      S_DRN: if (hold_vld_q) begin
        word_free = 1'b1;
        if (hold_lst_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          ok_d    = 1'b0;
          err_o_d = err_q;
        end
      end
      default: begin
        state_d = S_LEN;
        cnt_d   = 32'd0;
      end
    endcase

    // Upstream closed the chunk before its CRC was complete.
    if (consume && word_end && hold_lst_q && !crc_end) begin
      err_d   = 1'b1;
      state_d = S_DONE;
      cnt_d   = 32'd0;
      done_d  = 1'b1;
      ok_d    = 1'b0;
      err_o_d = 1'b1;
    end

    if (consume) begin
      if (word_end || crc_end) word_free = 1'b1;
      else                     bidx_d    = bidx_q + 2'd1;
    end
    if (word_free) begin
      hold_vld_d = 1'b0;
      bidx_d     = 2'd0;
    end
    if (accept) begin
      hold_d     = dat_i;
      hold_lst_d = lst_i;
      hold_vld_d = 1'b1;
      bidx_d     = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LEN;
      hold_q     <= '0;
      hold_lst_q <= 1'b0;
      hold_vld_q <= 1'b0;
      bidx_q     <= '0;
      cnt_q      <= '0;
      len_sh_q   <= '0;
      typ_sh_q   <= '0;
      rcv_q      <= '0;
      crc_q      <= 32'hFFFF_FFFF;
      err_q      <= 1'b0;
      len_o_q    <= '0;
      typ_o_q    <= '0;
      byt_val_q  <= 1'b0;
      byt_q      <= '0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_o_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_lst_q <= hold_lst_d;
      hold_vld_q <= hold_vld_d;
      bidx_q     <= bidx_d;
      cnt_q      <= cnt_d;
      len_sh_q   <= len_sh_d;
      typ_sh_q   <= typ_sh_d;
      rcv_q      <= rcv_d;
      crc_q      <= crc_d;
      err_q      <= err_d;
      len_o_q    <= len_o_d;
      typ_o_q    <= typ_o_d;
      byt_val_q  <= byt_val_d;
      byt_q      <= byt_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      err_o_q    <= err_o_d;
    end
  end

  assign byt_val_o = byt_val_q;
  assign byt_o     = byt_q;
  assign len_o     = len_o_q;
  assign typ_o     = typ_o_q;
  assign done_o    = done_q;
  assign ok_o      = ok_q;
  assign err_o     = err_o_q;

endmodule

// File: tb/tb_png_chunk_chk.sv
// Directed bench for png_chunk_chk: known PNG chunks, CRC/framing errors,
// val_i gaps and a mid-chunk reset.
module tb_png_chunk_chk;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        val_i = 1'b0;
  logic        lst_i = 1'b0;
  logic [31:0] dat_i = '0;
  logic        rdy_o, byt_val_o, done_o, ok_o, err_o;
  logic [7:0]  byt_o;
  logic [31:0] len_o, typ_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int hs_cyc = 0;
  logic        last_ok, last_err;
  logic [31:0] last_len, last_typ;
  logic [7:0]  bytes_q[$];

  png_chunk_chk dut (
    .clk(clk), .rst(rst), .val_i(val_i), .rdy_o(rdy_o), .dat_i(dat_i), .lst_i(lst_i),
    .byt_val_o(byt_val_o), .byt_o(byt_o), .len_o(len_o), .typ_o(typ_o),
    .done_o(done_o), .ok_o(ok_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byt_val_o) bytes_q.push_back(byt_o);
    if (done_o) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      last_ok  = ok_o;
      last_err = err_o;
      last_len = len_o;
      last_typ = typ_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] w, input logic l, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    val_i = 1'b1;
    dat_i = w;
    lst_i = l;
    t = 0;
    while (rdy_o !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("send_rdy", {31'd0, rdy_o}, 32'd1);
    hs_cyc = cyc;
    @(posedge clk);
    #1;
    val_i = 1'b0;
    lst_i = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string tag);
    int t;
    t = 0;
    while (done_cnt == prev && t < 100) begin
      @(posedge clk);
      t++;
    end
    check(tag, done_cnt, prev + 1);
  endtask

  logic [31:0] ihdr[7];
  logic [7:0]  ihdr_bytes[13];
  int prev;
  int first_hs;

  initial begin
    ihdr = '{32'h0000000D, 32'h49484452, 32'h00000001, 32'h00000001,
             32'h08060000, 32'h001F15C4, 32'h89AABBCC};
    ihdr_bytes = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
                   8'h08, 8'h06, 8'h00, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rdy",     {31'd0, rdy_o},     32'd1);
    check("rst_byt_val", {31'd0, byt_val_o}, 32'd0);
    check("rst_done",    {31'd0, done_o},    32'd0);
    check("rst_ok",      {31'd0, ok_o},      32'd0);
    check("rst_err",     {31'd0, err_o},     32'd0);
    check("rst_byt",     {24'd0, byt_o},     32'd0);
    check("rst_len",     len_o,              32'd0);
    check("rst_typ",     typ_o,              32'd0);
    $display("txn reset: done");

    // IEND, back-to-back words
    prev = done_cnt;
    bytes_q.delete();
    send(32'h00000000, 1'b0, 0);
    first_hs = hs_cyc;
    send(32'h49454E44, 1'b0, 0);
    send(32'hAE426082, 1'b1, 0);
    wait_done(prev, "iend_done");
    check("iend_ok",      {31'd0, last_ok},  32'd1);
    check("iend_err",     {31'd0, last_err}, 32'd0);
    check("iend_len",     last_len,          32'd0);
    check("iend_typ",     last_typ,          32'h49454E44);
    check("iend_nbytes",  bytes_q.size(),    32'd0);
    check("iend_latency", done_cyc - first_hs, 32'd13);
    $display("txn IEND: ok=%b err=%b latency=%0d", last_ok, last_err, done_cyc - first_hs);

    // IHDR 1x1 RGBA with pad bytes after the CRC
    prev = done_cnt;
    bytes_q.delete();
    for (int i = 0; i < 7; i++) send(ihdr[i], (i == 6), 0);
    wait_done(prev, "ihdr_done");
    check("ihdr_ok",     {31'd0, last_ok},  32'd1);
    check("ihdr_err",    {31'd0, last_err}, 32'd0);
    check("ihdr_len",    last_len,          32'h0000000D);
    check("ihdr_typ",    last_typ,          32'h49484452);
    check("ihdr_nbytes", bytes_q.size(),    32'd13);
    for (int i = 0; i < 13; i++) begin
      if (i < bytes_q.size()) check($sformatf("ihdr_byte%0d", i), {24'd0, bytes_q[i]}, {24'd0, ihdr_bytes[i]});
    end
    $display("txn IHDR: ok=%b err=%b bytes=%0d", last_ok, last_err, bytes_q.size());

    // IEND with a corrupted CRC
    prev = done_cnt;
    send(32'h00000000, 1'b0, 0);
    send(32'h49454E44, 1'b0, 0);
    send(32'hAE426083, 1'b1, 0);
    wait_done(prev, "badcrc_done");
    check("badcrc_ok",  {31'd0, last_ok},  32'd0);
    check("badcrc_err", {31'd0, last_err}, 32'd0);
    $display("txn bad CRC: ok=%b err=%b", last_ok, last_err);

    // lst_i arrives on the type word
    prev = done_cnt;
    send(32'h00000000, 1'b0, 0);
    send(32'h49454E44, 1'b1, 0);
    wait_done(prev, "early_done");
    check("early_ok",  {31'd0, last_ok},  32'd0);
    check("early_err", {31'd0, last_err}, 32'd1);
    $display("txn early lst: ok=%b err=%b", last_ok, last_err);

    // Next chunk must be framed correctly again
    prev = done_cnt;
    send(32'h00000000, 1'b0, 1);
    send(32'h49454E44, 1'b0, 0);
    send(32'hAE426082, 1'b1, 0);
    wait_done(prev, "resync_done");
    check("resync_ok",  {31'd0, last_ok},  32'd1);
    check("resync_err", {31'd0, last_err}, 32'd0);
    $display("txn resync IEND: ok=%b err=%b", last_ok, last_err);

    // CRC word without lst_i: drain until the lst_i word
    prev = done_cnt;
    send(32'h00000000, 1'b0, 0);
    send(32'h49454E44, 1'b0, 0);
    send(32'hAE426082, 1'b0, 0);
    repeat (10) @(negedge clk);
    check("nolst_nodone", done_cnt, prev);
    send(32'hDEADBEEF, 1'b1, 0);
    wait_done(prev, "nolst_done");
    check("nolst_ok",  {31'd0, last_ok},  32'd0);
    check("nolst_err", {31'd0, last_err}, 32'd1);
    $display("txn missing lst: ok=%b err=%b", last_ok, last_err);

    // Illegal length, three junk words
    prev = done_cnt;
    bytes_q.delete();
    send(32'h80000000, 1'b0, 0);
    send(32'h12345678, 1'b0, 0);
    send(32'h9ABCDEF0, 1'b0, 0);
    repeat (10) @(negedge clk);
    check("badlen_nodone", done_cnt, prev);
    send(32'h0BADF00D, 1'b1, 0);
    wait_done(prev, "badlen_done");
    check("badlen_ok",     {31'd0, last_ok},  32'd0);
    check("badlen_err",    {31'd0, last_err}, 32'd1);
    check("badlen_len",    last_len,          32'h80000000);
    check("badlen_nbytes", bytes_q.size(),    32'd0);
    $display("txn bad length: ok=%b err=%b len=%h", last_ok, last_err, last_len);

    // IHDR with random val_i gaps
    prev = done_cnt;
    bytes_q.delete();
    for (int i = 0; i < 7; i++) send(ihdr[i], (i == 6), int'($urandom_range(0, 5)));
    wait_done(prev, "gap_done");
    check("gap_ok",     {31'd0, last_ok}, 32'd1);
    check("gap_nbytes", bytes_q.size(),   32'd13);
    $display("txn gapped IHDR: ok=%b bytes=%0d", last_ok, bytes_q.size());

    // Reset in the middle of IHDR, then IEND
    prev = done_cnt;
    for (int i = 0; i < 3; i++) send(ihdr[i], 1'b0, int'($urandom_range(0, 3)));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rstmid_nodone", done_cnt, prev);
    send(32'h00000000, 1'b0, int'($urandom_range(0, 3)));
    send(32'h49454E44, 1'b0, int'($urandom_range(0, 3)));
    send(32'hAE426082, 1'b1, int'($urandom_range(0, 3)));
    wait_done(prev, "rstmid_done");
    repeat (20) @(negedge clk);
    check("rstmid_one_done", done_cnt, prev + 1);
    check("rstmid_ok",  {31'd0, last_ok},  32'd1);
    check("rstmid_err", {31'd0, last_err}, 32'd0);
    $display("txn reset mid-IHDR then IEND: ok=%b err=%b", last_ok, last_err);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
